bt_cmd_responder: RTL and testbench

- Bluetooth-module-side endpoint of the serial command link driven by the player's command initiator.
- Enabled by `cmd_n`. Receives 8N1 UART command bytes on `RX` until a carriage return (0x0D), then replies on `TX` with a 4-byte acknowledgement.
- The initiator's response-received logic advances on each reply byte.
- Used as the BT module model in system benches, and as the reply path for any on-chip command consumer.

---
 rtl/bt_cmd_responder.sv | 146 ++++++++++++++
 tb/tb_bt_cmd_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_responder.sv
// bt_cmd_responder: UART command endpoint; collects CR-terminated commands and replies "AOK\r" or "ERR\r".
module bt_cmd_responder #(
  parameter int BAUD_DIV = 2604,
  parameter int MAX_LEN  = 16,
  parameter int TURN_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_n,
  input  logic       RX,
  output logic       TX,
  output logic       cmd_vld,
  output logic [7:0] cmd_op,
  output logic [4:0] cmd_len,
  output logic       err,
  output logic       busy
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [BW-1:0] B_END  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {DISABLED, COLLECT, DRAIN, TURN, RESPOND} st_t;
  logic [1:0] rx_sy, cn_sy;
  logic rx_s, cmdn_s, rx_p;
  rx_st_t rx_st;
  logic [BW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh, op0, cur;
  logic rx_tick, rx_done, rx_ferr;
  st_t state, st_n;
  logic [4:0] cnt;
  logic [TW-1:0] tc;
  logic [3:0] tx_bit;
  logic [1:0] tx_idx;
  logic rep_err;
  logic is_cr, in_col, vld_c, ovf_c, acc_c, ferr_c, drn_cr, turn_end, tx_tick, byte_end, tx_last;
  assign rx_s     = rx_sy[1];
  assign cmdn_s   = cn_sy[1];
  assign rx_tick  = rx_cnt == ((rx_st == R_START) ? B_HALF : B_END);
  assign rx_done  = rx_st == R_STOP && rx_tick && rx_s;
  assign rx_ferr  = rx_st == R_STOP && rx_tick && !rx_s;
  assign is_cr    = rx_sh == 8'h0D;
  assign in_col   = state == COLLECT && !cmdn_s;
  assign vld_c    = in_col && rx_done && is_cr && cnt != 5'd0;
  assign ovf_c    = in_col && rx_done && !is_cr && cnt == 5'(MAX_LEN);
  assign acc_c    = in_col && rx_done && !is_cr && cnt != 5'(MAX_LEN);
  assign ferr_c   = (state == COLLECT || state == DRAIN) && !cmdn_s && rx_ferr;
  assign drn_cr   = state == DRAIN && !cmdn_s && rx_done && is_cr;
  assign turn_end = state == TURN && !cmdn_s && tc == TW'(TURN_CYC - 1);
  assign tx_tick  = tx_cnt == B_END;
  assign byte_end = state == RESPOND && tx_tick && tx_bit == 4'd9;
  // A late cmd_n rise still lets the byte in flight finish its stop bit.
  assign tx_last  = byte_end && (tx_idx == 2'd3 || cmdn_s);
  assign busy     = state == TURN || state == RESPOND;
  assign cur = (tx_idx == 2'd0) ? (rep_err ? 8'h45 : 8'h41) :
               (tx_idx == 2'd1) ? (rep_err ? 8'h52 : 8'h4F) :
               (tx_idx == 2'd2) ? (rep_err ? 8'h52 : 8'h4B) : 8'h0D;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sy  <= 2'b11;
      cn_sy  <= 2'b11;
      rx_p   <= 1'b1;
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_sy  <= {rx_sy[0], RX};
      cn_sy  <= {cn_sy[0], cmd_n};
      rx_p   <= rx_s;
      rx_cnt <= (rx_st == R_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_st == R_IDLE) begin
        if (rx_p && !rx_s) rx_st <= R_START;
      end else if (rx_st == R_START) begin
        if (rx_tick) rx_st <= rx_s ? R_IDLE : R_DATA;
      end else if (rx_st == R_DATA) begin
        if (rx_tick) begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end
      end else if (rx_tick) begin
        rx_st <= R_IDLE;
      end
    end
  end
  always_comb begin
    st_n = state;
    case (state)
      DISABLED: st_n = cmdn_s ? DISABLED : COLLECT;
      COLLECT:  st_n = cmdn_s ? DISABLED : vld_c ? TURN : ovf_c ? DRAIN : COLLECT;
      DRAIN:    st_n = cmdn_s ? DISABLED : drn_cr ? TURN : ferr_c ? COLLECT : DRAIN;
      TURN:     st_n = cmdn_s ? DISABLED : turn_end ? RESPOND : TURN;
      RESPOND:  st_n = tx_last ? (cmdn_s ? DISABLED : COLLECT) : RESPOND;
      default:  st_n = DISABLED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISABLED;
      cmd_vld <= 1'b0;
      cmd_op  <= '0;
      cmd_len <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      op0     <= '0;
      rep_err <= 1'b0;
      tc      <= '0;
      TX      <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_idx  <= '0;
    end else begin
      state   <= st_n;
      cmd_vld <= vld_c;
      if (vld_c) begin
        cmd_op  <= op0;
        cmd_len <= cnt;
      end
      err <= (ferr_c || ovf_c) ? 1'b1 : vld_c ? 1'b0 : err;
      cnt <= (st_n != COLLECT || ferr_c) ? '0 : acc_c ? cnt + 1'b1 : cnt;
      if (acc_c && cnt == 5'd0) op0 <= rx_sh;
      if (vld_c || drn_cr) rep_err <= drn_cr;
      tc <= (state == TURN) ? tc + 1'b1 : '0;
      if (turn_end) begin
        TX     <= 1'b0;
        tx_cnt <= '0;
        tx_bit <= '0;
        tx_idx <= '0;
      end else if (state == RESPOND) begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
        if (byte_end) begin
          TX     <= tx_last;
          tx_bit <= '0;
          tx_idx <= tx_idx + 1'b1;
        end else if (tx_tick) begin
          TX     <= (tx_bit == 4'd8) ? 1'b1 : cur[tx_bit[2:0]];
          tx_bit <= tx_bit + 1'b1;
        end
      end else begin
        TX <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bt_cmd_responder.sv
// tb_bt_cmd_responder: directed bench with a bit-exact TX decoder and cmd_vld monitor.
module tb_bt_cmd_responder;
  logic clk = 1'b0;
  logic rst_n, cmd_n, rx;
  logic tx, cmd_vld, err, busy;
  logic [7:0] cmd_op;
  logic [4:0] cmd_len;
  int passed = 0, total = 0, cyc = 0, vld_cnt = 0, vld_cyc = 0, wbad = 0, dstart;
  logic vld_busy;
  logic [9:0] dbits;
  logic [7:0] tx_q[$];
  int st_q[$];

  bt_cmd_responder #(.BAUD_DIV(16), .MAX_LEN(16), .TURN_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_n(cmd_n), .RX(rx), .TX(tx),
    .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_len(cmd_len), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (cmd_vld === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
      vld_busy = busy;
    end

  // Samples every cycle of each bit so a wrong bit width shows up in wbad.
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      dstart = cyc;
      for (int b = 0; b < 10; b++)
        for (int i = 0; i < 16; i++) begin
          if (b != 0 || i != 0) @(negedge clk);
          if (i == 0) dbits[b] = tx;
          else if (tx !== dbits[b]) wbad++;
        end
      if (dbits[0] !== 1'b0 || dbits[9] !== 1'b1) wbad++;
      tx_q.push_back(dbits[8:1]);
      st_q.push_back(dstart);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_at();
    send(8'h41);
    send(8'h54);
    send(8'h0D);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, tx_q.size() >= n, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_vld", cmd_vld, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // "S|\r" -> AOK
    tx_q.delete();
    st_q.delete();
    send(8'h53);
    send(8'h7C);
    send(8'h0D);
    wait_bytes(4, "aok1_wait");
    chk("aok1_vld_cnt", vld_cnt, 1);
    chk("aok1_op", cmd_op, 8'h53);
    chk("aok1_len", cmd_len, 2);
    chk("aok1_busy_at_vld", vld_busy, 1);
    chk("aok1_turn_gap", st_q[0] - vld_cyc, 20);
    chk("aok1_b0", tx_q[0], 8'h41);
    chk("aok1_b1", tx_q[1], 8'h4F);
    chk("aok1_b2", tx_q[2], 8'h4B);
    chk("aok1_b3", tx_q[3], 8'h0D);
    chk("aok1_bit_width", wbad, 0);
    chk("aok1_b_gap", st_q[1] - st_q[0], 160);
    repeat (20) @(negedge clk);
    chk("aok1_idle_busy", busy, 0);
    // overflow: 17 x 'A' then CR -> ERR
    tx_q.delete();
    for (int i = 0; i < 17; i++) send(8'h41);
    send(8'h0D);
    wait_bytes(4, "ovf_wait");
    chk("ovf_no_vld", vld_cnt, 1);
    chk("ovf_err", err, 1);
    chk("ovf_b0", tx_q[0], 8'h45);
    chk("ovf_b1", tx_q[1], 8'h52);
    chk("ovf_b2", tx_q[2], 8'h52);
    chk("ovf_b3", tx_q[3], 8'h0D);
    repeat (20) @(negedge clk);
    tx_q.delete();
    send_at();
    chk("at_vld_cnt", vld_cnt, 2);
    chk("at_op", cmd_op, 8'h41);
    chk("at_len", cmd_len, 2);
    chk("at_err_clr", err, 0);
    wait_bytes(4, "at_wait");
    chk("at_b0", tx_q[0], 8'h41);
    // framing error
    repeat (20) @(negedge clk);
    tx_q.delete();
    send(8'h55, 1'b0);
    repeat (100) @(negedge clk);
    chk("ferr_err", err, 1);
    chk("ferr_no_reply", tx_q.size(), 0);
    chk("ferr_busy", busy, 0);
    send(8'h56);
    send(8'h0D);
    chk("v_vld_cnt", vld_cnt, 3);
    chk("v_op", cmd_op, 8'h56);
    chk("v_len", cmd_len, 1);
    chk("v_err_clr", err, 0);
    wait_bytes(4, "v_wait");
    chk("v_b1", tx_q[1], 8'h4F);
    chk("v_b2", tx_q[2], 8'h4B);
    // disabled
    repeat (20) @(negedge clk);
    cmd_n = 1'b1;
    repeat (10) @(negedge clk);
    tx_q.delete();
    send_at();
    repeat (200) @(negedge clk);
    chk("dis_no_vld", vld_cnt, 3);
    chk("dis_no_reply", tx_q.size(), 0);
    chk("dis_tx_idle", tx, 1);
    cmd_n = 1'b0;
    repeat (10) @(negedge clk);
    send_at();
    wait_bytes(4, "en_wait");
    chk("en_vld_cnt", vld_cnt, 4);
    chk("en_b0", tx_q[0], 8'h41);
    chk("en_b3", tx_q[3], 8'h0D);
    // cmd_n rises during the second reply byte
    repeat (20) @(negedge clk);
    tx_q.delete();
    send_at();
    wait_bytes(1, "abort_wait");
    repeat (40) @(negedge clk);
    cmd_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("abort_nbytes", tx_q.size(), 2);
    chk("abort_b1", tx_q[1], 8'h4F);
    chk("abort_tx_idle", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_bit_width", wbad, 0);
    // lone CR
    cmd_n = 1'b0;
    repeat (10) @(negedge clk);
    tx_q.delete();
    send(8'h0D);
    repeat (200) @(negedge clk);
    chk("lone_cr_no_reply", tx_q.size(), 0);
    chk("lone_cr_no_vld", vld_cnt, 5);
    chk("lone_cr_busy", busy, 0);
    // reset mid-reply
    send_at();
    wait_bytes(1, "mid_wait");
    repeat (3) @(negedge clk);
    chk("mid_tx_low", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_vld", cmd_vld, 0);
    chk("mid_rst_op", cmd_op, 0);
    chk("mid_rst_len", cmd_len, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
